// File: rtl/mul8_arb_pkg.sv
// Shared types and helpers for the two-client MUL8 arbiter.
package mul8_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    ACK  = 2'd2
  } state_e;

  typedef enum logic {
    GNT_A = 1'b0,
    GNT_B = 1'b1
  } gnt_e;

  localparam int unsigned CNT_W = 4;

  // Round-robin pick: on a tie the side that was not served last wins.
  function automatic gnt_e pick_grant(input logic ra, input logic rb, input gnt_e last);
    if (ra && rb) begin
      return (last == GNT_A) ? GNT_B : GNT_A;
    end else if (ra) begin
      return GNT_A;
    end else begin
      return GNT_B;
    end
  endfunction

endpackage

// File: rtl/mul8.sv
// Combinational 8x8 -> 16 unsigned multiplier.
module mul8 (
  input  logic [7:0]  x,
  input  logic [7:0]  y,
  output logic [15:0] m
);

  // Zero-extend before multiplying so the full 16-bit product is kept.
  always_comb begin
    m = {8'd0, x} * {8'd0, y};
  end

endmodule

// File: rtl/mul8_shared_arbiter.sv
// Round-robin arbiter sharing one MUL8 between two 4-phase requesters.
module mul8_shared_arbiter
  import mul8_arb_pkg::*;
#(
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic        clock,
  input  logic        reset_,
  input  logic        req_a,
  input  logic [7:0]  xa,
  input  logic [7:0]  ya,
  output logic        ack_a,
  output logic [15:0] m_a,
  input  logic        req_b,
  input  logic [7:0]  xb,
  input  logic [7:0]  yb,
  output logic        ack_b,
  output logic [15:0] m_b,
  output logic        busy
);

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_CYCLES - 1);

  state_e            state_q, state_d;
  gnt_e              grant_q, grant_d;
  gnt_e              last_q,  last_d;
  gnt_e              next_gnt;
  logic [7:0]        x_q, x_d;
  logic [7:0]        y_q, y_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [15:0]       m_a_d, m_b_d;
  logic              ack_a_d, ack_b_d;
  logic              req_g;
  logic [15:0]       prod;

  // The multiplier only ever sees the operands latched at grant time.
  mul8 u_mul8 (
    .x(x_q),
    .y(y_q),
    .m(prod)
  );

  assign next_gnt = pick_grant(req_a, req_b, last_q);
  assign req_g    = (grant_q == GNT_A) ? req_a : req_b;
  assign busy     = (state_q != IDLE);

  // State and datapath registers; reset abandons any service in progress.
  always_ff @(posedge clock or negedge reset_) begin
    if (!reset_) begin
      state_q <= IDLE;
      grant_q <= GNT_A;
      last_q  <= GNT_B;
      x_q     <= '0;
      y_q     <= '0;
      cnt_q   <= '0;
      m_a     <= '0;
      m_b     <= '0;
      ack_a   <= 1'b0;
      ack_b   <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      x_q     <= x_d;
      y_q     <= y_d;
      cnt_q   <= cnt_d;
      m_a     <= m_a_d;
      m_b     <= m_b_d;
      ack_a   <= ack_a_d;
      ack_b   <= ack_b_d;
    end
  end

  // Next-state and next-register values; everything holds unless a phase moves it.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    x_d     = x_q;
    y_d     = y_q;
    cnt_d   = cnt_q;
    m_a_d   = m_a;
    m_b_d   = m_b;
    ack_a_d = ack_a;
    ack_b_d = ack_b;
    case (state_q)
      IDLE: begin
        if (req_a || req_b) begin
          grant_d = next_gnt;
          x_d     = (next_gnt == GNT_A) ? xa : xb;
          y_d     = (next_gnt == GNT_A) ? ya : yb;
          cnt_d   = CNT_LOAD;
          state_d = CALC;
        end
      end
      CALC: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          if (grant_q == GNT_A) begin
            m_a_d   = prod;
            ack_a_d = 1'b1;
          end else begin
            m_b_d   = prod;
            ack_b_d = 1'b1;
          end
          state_d = ACK;
        end
      end
      ACK: begin
        if (!req_g) begin
          ack_a_d = 1'b0;
          ack_b_d = 1'b0;
          last_d  = grant_q;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_mul8_shared_arbiter.sv
// Directed self-checking bench for mul8_shared_arbiter.
module tb_mul8_shared_arbiter;

  logic        clock = 1'b0;
  logic        reset_ = 1'b0;
  logic        req_a = 1'b0, req_b = 1'b0;
  logic [7:0]  xa = '0, ya = '0, xb = '0, yb = '0;
  logic        ack_a, ack_b, busy;
  logic [15:0] m_a, m_b;

  logic        req_a4 = 1'b0, req_b4 = 1'b0;
  logic [7:0]  xa4 = '0, ya4 = '0, xb4 = '0, yb4 = '0;
  logic        ack_a4, ack_b4, busy4;
  logic [15:0] m_a4, m_b4;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  mul8_shared_arbiter #(.WAIT_CYCLES(1)) dut (
    .clock(clock), .reset_(reset_),
    .req_a(req_a), .xa(xa), .ya(ya), .ack_a(ack_a), .m_a(m_a),
    .req_b(req_b), .xb(xb), .yb(yb), .ack_b(ack_b), .m_b(m_b),
    .busy(busy)
  );

  mul8_shared_arbiter #(.WAIT_CYCLES(4)) dut4 (
    .clock(clock), .reset_(reset_),
    .req_a(req_a4), .xa(xa4), .ya(ya4), .ack_a(ack_a4), .m_a(m_a4),
    .req_b(req_b4), .xb(xb4), .yb(yb4), .ack_b(ack_b4), .m_b(m_b4),
    .busy(busy4)
  );

  // Advance one full clock; inputs are driven and outputs sampled at negedge.
  task automatic step();
    @(negedge clock);
  endtask

  task automatic test_reset();
    step();
    checks++; if (ack_a !== 1'b0) begin errors++; $display("FAIL rst_ack_a: got %0b expected 0", ack_a); end
    checks++; if (ack_b !== 1'b0) begin errors++; $display("FAIL rst_ack_b: got %0b expected 0", ack_b); end
    checks++; if (m_a !== 16'd0) begin errors++; $display("FAIL rst_m_a: got %0d expected 0", m_a); end
    checks++; if (m_b !== 16'd0) begin errors++; $display("FAIL rst_m_b: got %0d expected 0", m_b); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %0b expected 0", busy); end
    reset_ = 1'b1;
    step();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_busy: got %0b expected 0", busy); end
  endtask

  task automatic test_single_a();
    xa = 8'd5; ya = 8'd28; req_a = 1'b1;
    step();
    checks++; if (ack_a !== 1'b0) begin errors++; $display("FAIL a1_early_ack: got %0b expected 0", ack_a); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL a1_busy: got %0b expected 1", busy); end
    step();
    checks++; if (ack_a !== 1'b1) begin errors++; $display("FAIL a1_ack: got %0b expected 1", ack_a); end
    checks++; if (m_a !== 16'd140) begin errors++; $display("FAIL a1_m_a: got %0d expected 140", m_a); end
    checks++; if (m_b !== 16'd0) begin errors++; $display("FAIL a1_m_b: got %0d expected 0", m_b); end
    checks++; if (ack_b !== 1'b0) begin errors++; $display("FAIL a1_ack_b: got %0b expected 0", ack_b); end
    step();
    checks++; if (ack_a !== 1'b1) begin errors++; $display("FAIL a1_ack_hold: got %0b expected 1", ack_a); end
    req_a = 1'b0;
    step();
    checks++; if (ack_a !== 1'b0) begin errors++; $display("FAIL a1_ack_drop: got %0b expected 0", ack_a); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL a1_idle: got %0b expected 0", busy); end
    checks++; if (m_a !== 16'd140) begin errors++; $display("FAIL a1_m_a_held: got %0d expected 140", m_a); end
  endtask

  task automatic test_b_then_a();
    xb = 8'd10; yb = 8'd35; req_b = 1'b1;
    step(); step();
    checks++; if (ack_b !== 1'b1) begin errors++; $display("FAIL b2_ack: got %0b expected 1", ack_b); end
    checks++; if (m_b !== 16'd350) begin errors++; $display("FAIL b2_m_b: got %0d expected 350", m_b); end
    checks++; if (ack_a !== 1'b0) begin errors++; $display("FAIL b2_ack_a: got %0b expected 0", ack_a); end
    req_b = 1'b0;
    step();
    xa = 8'd255; ya = 8'd255; req_a = 1'b1;
    step(); step();
    checks++; if (ack_a !== 1'b1) begin errors++; $display("FAIL a2_ack: got %0b expected 1", ack_a); end
    checks++; if (m_a !== 16'd65025) begin errors++; $display("FAIL a2_m_a: got %0d expected 65025", m_a); end
    checks++; if (m_b !== 16'd350) begin errors++; $display("FAIL a2_m_b_held: got %0d expected 350", m_b); end
    req_a = 1'b0;
    step();
  endtask

  task automatic test_fairness();
    bit   seen;
    logic exp_b;
    reset_ = 1'b0;
    step();
    reset_ = 1'b1;
    step();
    xa = 8'd3; ya = 8'd7; xb = 8'd4; yb = 8'd6;
    req_a = 1'b1; req_b = 1'b1;
    for (int i = 0; i < 4; i++) begin
      seen = 1'b0;
      for (int t = 0; t < 10 && !seen; t++) begin
        step();
        checks++;
        if (ack_a && ack_b) begin errors++; $display("FAIL rr_both_ack: got a=%0b b=%0b expected not both", ack_a, ack_b); end
        if (ack_a || ack_b) seen = 1'b1;
      end
      checks++;
      if (!seen) begin
        errors++; $display("FAIL rr_timeout: service %0d got no ack expected ack within 10 cycles", i);
        break;
      end
      exp_b = (i % 2 == 1);
      checks++; if (ack_b !== exp_b) begin errors++; $display("FAIL rr_order: service %0d got ack_b=%0b expected %0b", i, ack_b, exp_b); end
      if (ack_b) begin
        checks++; if (m_b !== 16'd24) begin errors++; $display("FAIL rr_m_b: got %0d expected 24", m_b); end
        req_b = 1'b0;
      end else begin
        checks++; if (m_a !== 16'd21) begin errors++; $display("FAIL rr_m_a: got %0d expected 21", m_a); end
        req_a = 1'b0;
      end
      step();
      checks++; if ((ack_a | ack_b) !== 1'b0) begin errors++; $display("FAIL rr_ack_release: got a=%0b b=%0b expected 0", ack_a, ack_b); end
      req_a = 1'b1; req_b = 1'b1;
    end
    req_a = 1'b0; req_b = 1'b0;
    repeat (5) step();
  endtask

  task automatic test_operand_hold();
    xa = 8'd5; ya = 8'd9; req_a = 1'b1;
    step();
    xa = 8'd0;
    step();
    checks++; if (ack_a !== 1'b1) begin errors++; $display("FAIL hold_ack: got %0b expected 1", ack_a); end
    checks++; if (m_a !== 16'd45) begin errors++; $display("FAIL hold_m_a: got %0d expected 45", m_a); end
    req_a = 1'b0;
    step();
    xb = 8'd0; yb = 8'd42; req_b = 1'b1;
    step(); step();
    checks++; if (ack_b !== 1'b1) begin errors++; $display("FAIL zero_ack: got %0b expected 1", ack_b); end
    checks++; if (m_b !== 16'd0) begin errors++; $display("FAIL zero_m_b: got %0d expected 0", m_b); end
    req_b = 1'b0;
    step();
  endtask

  task automatic test_reset_mid();
    xa = 8'd7; ya = 8'd11; req_a = 1'b1;
    step();
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL mid_busy_pre: got %0b expected 1", busy); end
    reset_ = 1'b0;
    #1;
    checks++; if (ack_a !== 1'b0) begin errors++; $display("FAIL mid_ack_a: got %0b expected 0", ack_a); end
    checks++; if (ack_b !== 1'b0) begin errors++; $display("FAIL mid_ack_b: got %0b expected 0", ack_b); end
    checks++; if (m_a !== 16'd0) begin errors++; $display("FAIL mid_m_a: got %0d expected 0", m_a); end
    checks++; if (m_b !== 16'd0) begin errors++; $display("FAIL mid_m_b: got %0d expected 0", m_b); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_busy: got %0b expected 0", busy); end
    req_a = 1'b0;
    step();
    reset_ = 1'b1;
    step();
    xa = 8'd12; ya = 8'd12; req_a = 1'b1;
    step(); step();
    checks++; if (ack_a !== 1'b1) begin errors++; $display("FAIL post_ack: got %0b expected 1", ack_a); end
    checks++; if (m_a !== 16'd144) begin errors++; $display("FAIL post_m_a: got %0d expected 144", m_a); end
    req_a = 1'b0;
    step();
  endtask

  task automatic test_wait4();
    xa4 = 8'd20; ya4 = 8'd49; req_a4 = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      step();
      checks++; if (ack_a4 !== 1'b0) begin errors++; $display("FAIL w4_early_ack: edge %0d got %0b expected 0", i, ack_a4); end
    end
    step();
    checks++; if (ack_a4 !== 1'b1) begin errors++; $display("FAIL w4_ack: got %0b expected 1", ack_a4); end
    checks++; if (m_a4 !== 16'd980) begin errors++; $display("FAIL w4_m_a: got %0d expected 980", m_a4); end
    req_a4 = 1'b0;
    step();
    checks++; if (ack_a4 !== 1'b0) begin errors++; $display("FAIL w4_release: got %0b expected 0", ack_a4); end
    xa4 = 8'd3; ya4 = 8'd5; req_a4 = 1'b1;
    step();
    req_a4 = 1'b0;
    repeat (3) step();
    checks++; if (ack_a4 !== 1'b0) begin errors++; $display("FAIL w4_drop_early: got %0b expected 0", ack_a4); end
    step();
    checks++; if (ack_a4 !== 1'b1) begin errors++; $display("FAIL w4_drop_pulse: got %0b expected 1", ack_a4); end
    checks++; if (m_a4 !== 16'd15) begin errors++; $display("FAIL w4_drop_m_a: got %0d expected 15", m_a4); end
    step();
    checks++; if (ack_a4 !== 1'b0) begin errors++; $display("FAIL w4_drop_end: got %0b expected 0", ack_a4); end
    checks++; if (busy4 !== 1'b0) begin errors++; $display("FAIL w4_drop_idle: got %0b expected 0", busy4); end
  endtask

  initial begin
    test_reset();
    test_single_a();
    test_b_then_a();
    test_fairness();
    test_operand_hold();
    test_reset_mid();
    test_wait4();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
